// File: rtl/bdl_writeback.sv
// DELQA buffer-descriptor write-back engine.
// Copies one (flag mode) or two (status mode) descriptor words from the BDL
// register file into host memory through the Q-bus DMA master.
module bdl_writeback #(
  parameter int NUM = 6,
  parameter int AW  = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [AW-1:0]     bdl_base,
  output logic [NUM/2-1:0]  reg_addr,
  input  logic [15:0]       reg_q,
  output logic              dma_req,
  output logic [AW-1:0]     dma_addr,
  output logic [15:0]       dma_wdata,
  input  logic              dma_ack,
  input  logic              dma_err,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IW = NUM / 2;

  // Word list: flag mode writes word 0; status mode writes the last word,
  // then the one before it, so status1 lands last in host memory.
  localparam logic [IW-1:0] FLAG_WORD = '0;
  localparam logic [IW-1:0] STAT_HI   = IW'(NUM - 1);
  localparam logic [IW-1:0] STAT_LO   = IW'(NUM - 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    NEXT,
    FIN
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q,  base_d;
  logic            mode_q,  mode_d;
  logic [IW-1:0]   idx_q,   idx_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            err_q,   err_d;
  logic [AW-1:0]   word_off;

  // Byte offset of the current word; the sum wraps modulo 2^AW.
  assign word_off = AW'({idx_q, 1'b0});

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = bdl_base & {{(AW-1){1'b1}}, 1'b0};
          mode_d  = mode;
          idx_d   = mode ? STAT_HI : FLAG_WORD;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Sample the register file right before this word's own write.
        wdata_d = reg_q;
        addr_d  = base_q + word_off;
        state_d = REQ;
      end
      REQ: begin
        if (dma_err) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (dma_ack) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (mode_q && (idx_q == STAT_HI)) begin
          idx_d   = STAT_LO;
          state_d = LOAD;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign reg_addr  = idx_q;
  assign dma_req   = (state_q == REQ);
  assign dma_addr  = addr_q;
  assign dma_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign err       = err_q;

endmodule

// File: doc/bdl_writeback.md
Name: bdl_writeback

Overview:
- DMA write-back engine for DELQA buffer descriptors.
- Reads descriptor words from the local BDL register file through its combinational read port and writes the selected words back to host memory over the Q-bus DMA master.
- Two jobs:
  - Flag mode marks a descriptor "in use" by writing the flag word.
  - Status mode returns status words 2 and 1, in that order, so the host sees a complete status once status1 changes.

Parameters:
- NUM, 6, number of words per descriptor in the BDL register file; word index width is NUM/2 (3 bits at default).
- AW, 22, Q-bus DMA address width in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request, sampled only in IDLE.
- mode  input  1  0 = flag write (word 0 only); 1 = status write (word 5, then word 4).
- bdl_base  input  AW  host byte address of descriptor word 0; bit 0 is ignored and treated as 0.
- reg_addr  output  NUM/2  BDL register file word index.
- reg_q  input  16  BDL register file read data, combinational from reg_addr.
- dma_req  output  1  DMA write request.
- dma_addr  output  AW  DMA byte address.
- dma_wdata  output  16  DMA write data.
- dma_ack  input  1  one-cycle pulse: current write completed.
- dma_err  input  1  one-cycle pulse: bus error (NXM/timeout), current write aborted.
- busy  output  1  high whenever not in IDLE.
- done  output  1  one-cycle pulse: sequence completed without error.
- err  output  1  one-cycle pulse: sequence aborted by dma_err.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - reg_addr=0, dma_req=0, dma_addr=0, dma_wdata=0.
  - busy=0, done=0, err=0.
  - Reset mid-transfer drops dma_req immediately. No further writes.
- States: IDLE, LOAD, REQ, NEXT, FIN.
- IDLE:
  - On start=1, latch bdl_base (bit 0 cleared) and mode.
  - Set the word-list pointer to the first entry: word 0 for mode 0, word 5 for mode 1.
  - Go to LOAD.
  - While not IDLE, start is ignored; no queueing.
- LOAD (1 cycle):
  - reg_addr = current word index.
  - At the clock edge, register reg_q into dma_wdata and base + 2*index (mod 2^AW) into dma_addr.
  - Go to REQ.
- REQ:
  - dma_req=1. dma_addr and dma_wdata held stable until the request ends.
  - dma_ack=1: dma_req drops next cycle; go to NEXT.
  - dma_err=1: dma_req drops next cycle; go to IDLE; err pulses 1 cycle.
  - dma_ack and dma_err in the same cycle: the error wins.
  - No timeout inside this block; the DMA master guarantees ack or err.
- NEXT (1 cycle):
  - If another word is listed (mode 1 after word 5), the pointer moves to word 4; go to LOAD.
  - Otherwise go to FIN.
- FIN (1 cycle): done=1, then IDLE.
- Timing from the start cycle T:
  - reg_addr valid in T+1.
  - dma_req first high at T+2.
  - With ack at cycle A for the last word, done is high at A+2.
- Per-word cost: 3 cycles plus the ack latency.
- Each word is read from the register file immediately before its own DMA write, so a register file update between words is reflected in the later word.
- Address wrap: base 3FFFF8 with word 5 gives 000002 (mod 2^22, no carry out).
- reg_addr holds its last value outside LOAD; reads have no side effects.

Test Plan:
- Flag write: reset, regfile word0=FFFF, base=017000, mode=0, start pulse -> dma_req at T+2 with dma_addr=017000 and dma_wdata=FFFF; ack after 3 cycles -> done pulse one cycle after NEXT; busy falls with done; exactly one DMA write.
- Status write: word5=0000, word4=2000, base=017010 -> first write addr 01701A data 0000; second write addr 017018 data 2000; exactly two writes, then done.
- Bus error on the first status word: dma_err during the word-5 request -> err=1 for one cycle, no done, no second request, IDLE with busy=0 next cycle.
- Simultaneous dma_ack and dma_err, plus start asserted while busy -> treated as error; the extra start produces no new sequence.
- Odd base and wrap: base=3FFFF9, mode=1 -> addresses 000002 then 000000.
- Async reset mid-REQ: rst_n low while dma_req=1 -> dma_req=0 without a clock edge; after release, no request until a new start.
